// File: rtl/obi_data_arbiter.sv
// Two-master / one-slave OBI data-port arbiter with a stall lock, a round-robin pointer
// and an in-order outstanding-ID queue that steers slave responses back to their issuer.
module obi_data_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          ROUND_ROBIN     = 1'b1
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic [31:0] m1_rdata_o,
   output logic        s_req_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic [31:0] s_rdata_i,
   output logic        resp_err_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
   endfunction

   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             id_q [MAX_OUTSTANDING];

   logic sel_s, locked_req_s, full_s, hs_s, push_s, pop_s, head_s, has_entry_s;

   assign full_s       = (count_q == CNT_MAX);
   assign has_entry_s  = (count_q != CNT_ZERO);
   assign locked_req_s = lock_id_q ? m1_req_i : m0_req_i;
   assign head_s       = id_q[rptr_q];

   // Master selection: a stalled address phase keeps its master, ties use the policy.
   always_comb begin
      sel_s = 1'b0;
      if (lock_q && locked_req_s) begin
         sel_s = lock_id_q;
      end else if (m0_req_i && !m1_req_i) begin
         sel_s = 1'b0;
      end else if (m1_req_i && !m0_req_i) begin
         sel_s = 1'b1;
      end else if (m0_req_i && m1_req_i) begin
         sel_s = ROUND_ROBIN ? ~last_grant_q : 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   assign s_req_o  = (m0_req_i | m1_req_i) & ~full_s;
   assign hs_s     = s_req_o & s_gnt_i;
   assign push_s   = hs_s;
   assign pop_s    = s_rvalid_i & has_entry_s;
   assign m0_gnt_o = hs_s & ~sel_s;
   assign m1_gnt_o = hs_s & sel_s;

   // Address-phase mux; the slave sees zeros whenever no request is presented.
   always_comb begin
      s_we_o    = 1'b0;
      s_be_o    = 4'h0;
      s_addr_o  = 32'h0;
      s_wdata_o = 32'h0;
      if (s_req_o) begin
         s_we_o    = sel_s ? m1_we_i    : m0_we_i;
         s_be_o    = sel_s ? m1_be_i    : m0_be_i;
         s_addr_o  = sel_s ? m1_addr_i  : m0_addr_i;
         s_wdata_o = sel_s ? m1_wdata_i : m0_wdata_i;
      end else begin
         s_we_o    = 1'b0;
      end
   end

   assign m0_rvalid_o = pop_s & ~head_s;
   assign m1_rvalid_o = pop_s & head_s;
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;
   // Gated by n_reset so an orphan response during reset is not flagged.
   assign resp_err_o  = s_rvalid_i & ~has_entry_s & n_reset;

   // Next-state for lock, round-robin pointer and queue bookkeeping.
   always_comb begin
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
      last_grant_d = last_grant_q;
      count_d      = count_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      if (hs_s) begin
         lock_d       = 1'b0;
         last_grant_d = sel_s;
      end else if (s_req_o) begin
         lock_d    = 1'b1;
         lock_id_d = sel_s;
      end else if (lock_q && !locked_req_s) begin
         lock_d = 1'b0;
      end else begin
         lock_d = lock_q;
      end
      if (push_s) begin
         wptr_d = ptr_inc(wptr_q);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = ptr_inc(rptr_q);
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every outstanding ID.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lock_q       <= 1'b0;
         lock_id_q    <= 1'b0;
         last_grant_q <= 1'b1;
         count_q      <= CNT_ZERO;
         wptr_q       <= PTR_ZERO;
         rptr_q       <= PTR_ZERO;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            id_q[i] <= 1'b0;
         end
      end else begin
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
         last_grant_q <= last_grant_d;
         count_q      <= count_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         if (push_s) begin
            id_q[wptr_q] <= sel_s;
         end
      end
   end

endmodule
